dmx_out: RTL

//   DMX512 transmitter, the send-side partner of the DMX receiver. Repeatedly sends

---
 rtl/dmx_pkg.sv | 36 +++
 rtl/dmx_byte_tx.sv | 71 +++++++
 rtl/dmx_out.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/dmx_pkg.sv
// Shared DMX512 definitions: protocol limits, frame FSM state encoding and
// a microsecond-to-clock conversion helper. Also imported by the receiver.
package dmx_pkg;

  localparam int DMX_BAUD     = 250_000;
  localparam int MIN_BREAK_US = 88;
  localparam int MIN_MAB_US   = 8;
  localparam int MAX_SLOTS    = 512;

  // Start bit + 8 data bits + 2 stop bits.
  localparam int SLOT_BITS    = 11;

  localparam logic [2:0] DMX_ST_IDLE  = 3'd0;
  localparam logic [2:0] DMX_ST_BREAK = 3'd1;
  localparam logic [2:0] DMX_ST_MAB   = 3'd2;
  localparam logic [2:0] DMX_ST_LOAD  = 3'd3;
  localparam logic [2:0] DMX_ST_SLOT  = 3'd4;
  localparam logic [2:0] DMX_ST_MBB   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = DMX_ST_IDLE,
    ST_BREAK = DMX_ST_BREAK,
    ST_MAB   = DMX_ST_MAB,
    ST_LOAD  = DMX_ST_LOAD,
    ST_SLOT  = DMX_ST_SLOT,
    ST_MBB   = DMX_ST_MBB
  } dmx_state_e;

  // 64-bit product so that e.g. 176 us * 48 MHz does not overflow.
  function automatic int us_to_clks(input longint clk_hz, input longint us);
    longint prod;
    prod = (clk_hz * us) / 64'd1_000_000;
    return int'(prod);
  endfunction

endpackage

// File: rtl/dmx_byte_tx.sv
// 8N2 serializer: on load_i captures byte_i and shifts out start bit, d[0..7]
// LSB first, then two stop bits, each BIT_CLKS clocks long. done_o is high
// during the final clock of the second stop bit.
module dmx_byte_tx
  import dmx_pkg::*;
#(
  parameter int BIT_CLKS = 192
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  output logic       tx_o,
  output logic       done_o
);

  localparam int CW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [3:0] LAST_BIT = 4'(SLOT_BITS - 1);

  logic [10:0]   shift_q, shift_d;
  logic [3:0]    bit_q, bit_d;
  logic [CW-1:0] clk_q, clk_d;
  logic          active_q, active_d;
  logic          last_clk;

  assign last_clk = (clk_q == CW'(BIT_CLKS - 1));
  assign done_o   = active_q && last_clk && (bit_q == LAST_BIT);
  assign tx_o     = active_q ? shift_q[0] : 1'b1;

  // Next-state: load a fresh frame, otherwise advance bit timing and shifter.
  always_comb begin
    shift_d  = shift_q;
    bit_d    = bit_q;
    clk_d    = clk_q;
    active_d = active_q;
    if (load_i) begin
      shift_d  = {2'b11, byte_i, 1'b0};
      bit_d    = 4'd0;
      clk_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (last_clk) begin
        clk_d = '0;
        if (bit_q == LAST_BIT) begin
          active_d = 1'b0;
        end else begin
          bit_d   = bit_q + 4'd1;
          shift_d = {1'b1, shift_q[10:1]};
        end
      end else begin
        clk_d = clk_q + CW'(1);
      end
    end
  end

  // Serializer state registers; idle line is mark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '1;
      bit_q    <= 4'd0;
      clk_q    <= '0;
      active_q <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      clk_q    <= clk_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/dmx_out.sv
// DMX512 transmitter. Sends BREAK, MAB, start code and NUM_SLOTS data bytes
// repeatedly while enable is high; a started frame always runs to completion.
//
// Memory read handshake: rd_en is a single-cycle request with rd_addr valid in
// the same cycle; there is no back-pressure. The memory must present rd_data
// exactly one clock later, and that is the only cycle in which it is sampled,
// so later writes to the same location only affect the next frame's fetch.
module dmx_out
  import dmx_pkg::*;
#(
  parameter int CLK_HZ    = 48_000_000,
  parameter int BAUD      = 250_000,
  parameter int NUM_SLOTS = 512,
  parameter int BREAK_US  = 176,
  parameter int MAB_US    = 12,
  parameter int MBB_US    = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] start_code,
  output logic       rd_en,
  output logic [8:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       tx,
  output logic       busy,
  output logic       frame_done,
  output dmx_state_e dbg_state
);

  localparam int BIT_CLKS   = CLK_HZ / BAUD;
  localparam int BREAK_CLKS = us_to_clks(longint'(CLK_HZ), longint'(BREAK_US));
  localparam int MAB_CLKS   = us_to_clks(longint'(CLK_HZ), longint'(MAB_US));
  localparam int MBB_CLKS   = us_to_clks(longint'(CLK_HZ), longint'(MBB_US));
  localparam int MAX_A      = (BREAK_CLKS > MAB_CLKS) ? BREAK_CLKS : MAB_CLKS;
  localparam int MAX_B      = (MBB_CLKS > BIT_CLKS) ? MBB_CLKS : BIT_CLKS;
  localparam int MAX_CLKS   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TW         = $clog2(MAX_CLKS + 1);
  localparam int MBB_LAST   = (MBB_CLKS > 0) ? MBB_CLKS - 1 : 0;

  if (CLK_HZ % BAUD != 0) begin : g_err_baud
    $error("dmx_out: CLK_HZ must be an integer multiple of BAUD");
  end
  if (NUM_SLOTS < 1 || NUM_SLOTS > MAX_SLOTS) begin : g_err_slots
    $error("dmx_out: NUM_SLOTS out of range 1..512");
  end
  if (BREAK_US < MIN_BREAK_US) begin : g_err_break
    $error("dmx_out: BREAK_US below DMX minimum");
  end
  if (MAB_US < MIN_MAB_US) begin : g_err_mab
    $error("dmx_out: MAB_US below DMX minimum");
  end

  dmx_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [9:0]    slot_q, slot_d;
  logic          ph_q, ph_d;
  logic [7:0]    sc_q, sc_d;
  logic          fd_q, fd_d;

  logic          ser_load;
  logic [7:0]    ser_byte;
  logic          ser_tx;
  logic          ser_done;
  logic          rd_en_c;

  dmx_byte_tx #(
    .BIT_CLKS (BIT_CLKS)
  ) u_byte_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (ser_load),
    .byte_i (ser_byte),
    .tx_o   (ser_tx),
    .done_o (ser_done)
  );

  // Frame FSM next-state and per-state strobes.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    slot_d   = slot_q;
    ph_d     = ph_q;
    sc_d     = sc_q;
    fd_d     = 1'b0;
    ser_load = 1'b0;
    ser_byte = sc_q;
    rd_en_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_BREAK;
          timer_d = '0;
          sc_d    = start_code;
        end
      end
      ST_BREAK: begin
        if (timer_q == TW'(BREAK_CLKS - 1)) begin
          state_d = ST_MAB;
          timer_d = '0;
          slot_d  = 10'd0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_MAB: begin
        if (timer_q == TW'(MAB_CLKS - 1)) begin
          state_d = ST_LOAD;
          timer_d = '0;
          ph_d    = 1'b0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_LOAD: begin
        // Two clocks for every slot so the slot period is constant; the
        // start code slot simply skips the memory request.
        if (!ph_q) begin
          ph_d    = 1'b1;
          rd_en_c = (slot_q != 10'd0);
        end else begin
          ph_d     = 1'b0;
          ser_load = 1'b1;
          ser_byte = (slot_q == 10'd0) ? sc_q : rd_data;
          state_d  = ST_SLOT;
        end
      end
      ST_SLOT: begin
        if (ser_done) begin
          if (slot_q < 10'(NUM_SLOTS)) begin
            slot_d  = slot_q + 10'd1;
            state_d = ST_LOAD;
            ph_d    = 1'b0;
          end else if (MBB_CLKS == 0) begin
            fd_d = 1'b1;
            if (enable) begin
              state_d = ST_BREAK;
              timer_d = '0;
              sc_d    = start_code;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            state_d = ST_MBB;
            timer_d = '0;
          end
        end
      end
      ST_MBB: begin
        if (timer_q == TW'(MBB_LAST)) begin
          fd_d = 1'b1;
          if (enable) begin
            state_d = ST_BREAK;
            timer_d = '0;
            sc_d    = start_code;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Frame FSM registers; reset forces the line back to mark immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      slot_q  <= 10'd0;
      ph_q    <= 1'b0;
      sc_q    <= 8'h00;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      slot_q  <= slot_d;
      ph_q    <= ph_d;
      sc_q    <= sc_d;
      fd_q    <= fd_d;
    end
  end

  assign rd_en      = rd_en_c;
  assign rd_addr    = (slot_q == 10'd0) ? 9'd0 : 9'(slot_q - 10'd1);
  assign tx         = (state_q == ST_BREAK) ? 1'b0 :
                      (state_q == ST_SLOT)  ? ser_tx : 1'b1;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = fd_q;
  assign dbg_state  = state_q;

endmodule
